// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and validity check for the cascade counter.
// Pure definitions: no latency, no backpressure.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic bcd_digit_valid(input bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_cascade_counter_if.sv
// Control/status bundle of the BCD cascade counter; the master drives requests.
// Plain wires: no latency, no backpressure.
interface bcd_cascade_counter_if #(
  parameter int DIGITS = 4
);

  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  en;
  logic                  up;
  logic [4*DIGITS-1:0]   q;
  logic                  tc;
  logic                  wrap;
  logic                  load_err;

  modport master (
    output clr, load, load_val, en, up,
    input  q, tc, wrap, load_err
  );

  modport slave (
    input  clr, load, load_val, en, up,
    output q, tc, wrap, load_err
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit cell; q updates one clk after clr/load/inc/dec, carry/borrow are combinational.
// No backpressure: inc/dec arrive pre-gated by the owner, clr > load > inc/dec.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  input  logic       load,
  input  bcd_digit_t ld_digit,
  output bcd_digit_t digit,
  output logic       carry_out,
  output logic       borrow_out
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = BCD_MIN;
    end else if (load) begin
      digit_d = ld_digit;
    end else if (inc) begin
      digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
    end else if (dec) begin
      digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  assign carry_out  = inc & (digit_q == BCD_MAX);
  assign borrow_out = dec & (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_cascade_counter.sv
// DIGITS-wide BCD up/down counter with validated load, combinational tc, registered wrap/load_err.
// Latency 1 clk to q; no backpressure, tc feeds the en of a following stage.
module bcd_cascade_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  bcd_cascade_counter_if.slave   bus
);

  logic [DIGITS-1:0]   inc;
  logic [DIGITS-1:0]   dec;
  logic [DIGITS-1:0]   carry;
  logic [DIGITS-1:0]   borrow;
  logic [4*DIGITS-1:0] q_vec;

  logic ld_ok;
  logic all_max;
  logic all_min;
  logic count_en;
  logic ld_digits;

  logic wrap_q, wrap_d;
  logic load_err_q, load_err_d;

  always_comb begin
    ld_ok   = 1'b1;
    all_max = 1'b1;
    all_min = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      ld_ok   = ld_ok   & bcd_digit_valid(bus.load_val[4*i +: 4]);
      all_max = all_max & (q_vec[4*i +: 4] == BCD_MAX);
      all_min = all_min & (q_vec[4*i +: 4] == BCD_MIN);
    end
  end

  assign count_en  = bus.en & ~bus.clr & ~bus.load;
  // A word with any non-decimal digit is rejected as a whole.
  assign ld_digits = bus.load & ~bus.clr & ld_ok;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : gen_digit
      if (g == 0) begin : gen_lsd
        assign inc[g] = count_en & bus.up;
        assign dec[g] = count_en & ~bus.up;
      end else begin : gen_upper
        assign inc[g] = carry[g-1];
        assign dec[g] = borrow[g-1];
      end

      bcd_digit u_digit (
        .clk        (clk),
        .rst        (rst),
        .inc        (inc[g]),
        .dec        (dec[g]),
        .clr        (bus.clr),
        .load       (ld_digits),
        .ld_digit   (bus.load_val[4*g +: 4]),
        .digit      (q_vec[4*g +: 4]),
        .carry_out  (carry[g]),
        .borrow_out (borrow[g])
      );
    end
  endgenerate

  // Carry/borrow out of the top digit only happens on an all-9s/all-0s wrap.
  always_comb begin
    wrap_d     = carry[DIGITS-1] | borrow[DIGITS-1];
    load_err_d = bus.load & ~bus.clr & ~ld_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.q        = q_vec;
  assign bus.tc       = count_en & (bus.up ? all_max : all_min);
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Bench for bcd_cascade_counter: a 2-digit instance plus two cascaded 1-digit instances,
// checked against an integer reference model.
module tb_bcd_cascade_counter;

  logic clk = 1'b0;
  logic rst;

  int n_cmp = 0;
  int n_err = 0;

  bcd_cascade_counter_if #(.DIGITS(2)) if2 ();
  bcd_cascade_counter_if #(.DIGITS(1)) ifa ();
  bcd_cascade_counter_if #(.DIGITS(1)) ifb ();

  bcd_cascade_counter #(.DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  bcd_cascade_counter #(.DIGITS(1)) duta (.clk(clk), .rst(rst), .bus(ifa));
  bcd_cascade_counter #(.DIGITS(1)) dutb (.clk(clk), .rst(rst), .bus(ifb));

  assign ifb.en   = ifa.tc;
  assign ifb.clr  = ifa.clr;
  assign ifb.load = ifa.load;
  assign ifb.up   = ifa.up;

  always #5 clk = ~clk;

  // Reference model: the count as a plain integer 0..99.
  int m_val;
  bit m_wrap, m_lerr;
  bit cur_c, cur_l, cur_e, cur_u;
  logic [7:0] cur_lv;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic bit lv_ok(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
  endfunction

  function automatic bit exp_tc();
    if (!cur_e || cur_c || cur_l) return 1'b0;
    return cur_u ? (m_val == 99) : (m_val == 0);
  endfunction

  task automatic model_edge();
    m_wrap = 1'b0;
    m_lerr = 1'b0;
    if (cur_c) begin
      m_val = 0;
    end else if (cur_l) begin
      if (lv_ok(cur_lv)) m_val = int'(cur_lv[7:4]) * 10 + int'(cur_lv[3:0]);
      else m_lerr = 1'b1;
    end else if (cur_e) begin
      if (cur_u) begin
        if (m_val == 99) begin m_val = 0; m_wrap = 1'b1; end
        else m_val = m_val + 1;
      end else begin
        if (m_val == 0) begin m_val = 99; m_wrap = 1'b1; end
        else m_val = m_val - 1;
      end
    end
  endtask

  task automatic drive(input bit c, input bit l, input logic [7:0] lv, input bit e, input bit u);
    cur_c = c; cur_l = l; cur_lv = lv; cur_e = e; cur_u = u;
    if2.clr = c; if2.load = l; if2.load_val = lv; if2.en = e; if2.up = u;
    ifa.clr = c; ifa.load = l; ifa.load_val = lv[3:0]; ifb.load_val = lv[7:4];
    ifa.en = e; ifa.up = u;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    #2;
    n_cmp++; if (if2.q !== 8'h00) begin n_err++; $display("FAIL reset_q got %h want 00", if2.q); end
    n_cmp++; if (if2.wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap got %b want 0", if2.wrap); end
    n_cmp++; if (if2.load_err !== 1'b0) begin n_err++; $display("FAIL reset_lerr got %b want 0", if2.load_err); end
    @(posedge clk); #1;
    n_cmp++; if (if2.q !== 8'h00) begin n_err++; $display("FAIL reset_hold_q got %h want 00", if2.q); end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    rst = 1'b0;
    m_val = 0; m_wrap = 1'b0; m_lerr = 1'b0;
  endtask

  task automatic test_count_up();
    int wraps = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      n_cmp++; if (if2.tc !== exp_tc()) begin n_err++; $display("FAIL up_tc step %0d got %b want %b", i, if2.tc, exp_tc()); end
      tick();
      n_cmp++; if (if2.q !== to_bcd(m_val)) begin n_err++; $display("FAIL up_q step %0d got %h want %h", i, if2.q, to_bcd(m_val)); end
      n_cmp++; if (if2.wrap !== m_wrap) begin n_err++; $display("FAIL up_wrap step %0d got %b want %b", i, if2.wrap, m_wrap); end
      if (if2.wrap === 1'b1) wraps++;
    end
    n_cmp++; if (wraps !== 1) begin n_err++; $display("FAIL up_wrap_count got %0d want 1", wraps); end
    n_cmp++; if (if2.q !== 8'h00) begin n_err++; $display("FAIL up_end_q got %h want 00", if2.q); end
  endtask

  task automatic test_count_down();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      n_cmp++; if (if2.tc !== exp_tc()) begin n_err++; $display("FAIL dn_tc step %0d got %b want %b", i, if2.tc, exp_tc()); end
      tick();
      n_cmp++; if (if2.q !== to_bcd(m_val)) begin n_err++; $display("FAIL dn_q step %0d got %h want %h", i, if2.q, to_bcd(m_val)); end
      n_cmp++; if (if2.wrap !== m_wrap) begin n_err++; $display("FAIL dn_wrap step %0d got %b want %b", i, if2.wrap, m_wrap); end
    end
    n_cmp++; if (if2.q !== 8'h97) begin n_err++; $display("FAIL dn_97 got %h want 97", if2.q); end
    drive(1'b0, 1'b1, 8'h91, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      n_cmp++; if (if2.q !== to_bcd(m_val)) begin n_err++; $display("FAIL dn_borrow_q step %0d got %h want %h", i, if2.q, to_bcd(m_val)); end
    end
    n_cmp++; if (if2.q !== 8'h89) begin n_err++; $display("FAIL dn_89 got %h want 89", if2.q); end
  endtask

  task automatic test_load();
    drive(1'b0, 1'b1, 8'h47, 1'b0, 1'b1);
    tick();
    n_cmp++; if (if2.q !== 8'h47) begin n_err++; $display("FAIL ld_q got %h want 47", if2.q); end
    n_cmp++; if (if2.load_err !== 1'b0) begin n_err++; $display("FAIL ld_lerr got %b want 0", if2.load_err); end
    drive(1'b0, 1'b1, 8'h4A, 1'b1, 1'b1);
    tick();
    n_cmp++; if (if2.q !== 8'h47) begin n_err++; $display("FAIL ld_bad_q got %h want 47", if2.q); end
    n_cmp++; if (if2.load_err !== 1'b1) begin n_err++; $display("FAIL ld_bad_lerr got %b want 1", if2.load_err); end
    drive(1'b0, 1'b1, 8'hA3, 1'b0, 1'b1);
    tick();
    n_cmp++; if (if2.q !== 8'h47) begin n_err++; $display("FAIL ld_badhi_q got %h want 47", if2.q); end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    n_cmp++; if (if2.load_err !== 1'b0) begin n_err++; $display("FAIL ld_lerr_clear got %b want 0", if2.load_err); end
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b1, 8'h12, 1'b1, 1'b1);
    tick();
    n_cmp++; if (if2.q !== 8'h00) begin n_err++; $display("FAIL pri_clr_q got %h want 00", if2.q); end
    drive(1'b0, 1'b1, 8'h12, 1'b1, 1'b0);
    n_cmp++; if (if2.tc !== 1'b0) begin n_err++; $display("FAIL pri_tc_load got %b want 0", if2.tc); end
    tick();
    n_cmp++; if (if2.q !== 8'h12) begin n_err++; $display("FAIL pri_load_q got %h want 12", if2.q); end
    n_cmp++; if (if2.wrap !== 1'b0) begin n_err++; $display("FAIL pri_load_wrap got %b want 0", if2.wrap); end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 8'h36, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    n_cmp++; if (if2.q !== 8'h37) begin n_err++; $display("FAIL ar_pre_q got %h want 37", if2.q); end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (if2.q !== 8'h00) begin n_err++; $display("FAIL ar_q got %h want 00", if2.q); end
    n_cmp++; if (if2.wrap !== 1'b0) begin n_err++; $display("FAIL ar_wrap got %b want 0", if2.wrap); end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    m_val = 0;
    tick();
    n_cmp++; if (if2.q !== 8'h01) begin n_err++; $display("FAIL ar_first_q got %h want 01", if2.q); end
    // A pending wrap pulse must also be discarded by reset.
    drive(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    n_cmp++; if (if2.wrap !== 1'b1) begin n_err++; $display("FAIL ar_wrap_pre got %b want 1", if2.wrap); end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (if2.wrap !== 1'b0) begin n_err++; $display("FAIL ar_wrap_kill got %b want 0", if2.wrap); end
    @(posedge clk); #1;
    rst = 1'b0;
    m_val = 0;
  endtask

  task automatic test_cascade();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 145; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, (i < 120));
      tick();
      n_cmp++; if ({ifb.q, ifa.q} !== to_bcd(m_val)) begin n_err++; $display("FAIL cas_q step %0d got %h want %h", i, {ifb.q, ifa.q}, to_bcd(m_val)); end
      n_cmp++; if (if2.q !== to_bcd(m_val)) begin n_err++; $display("FAIL cas_ref_q step %0d got %h want %h", i, if2.q, to_bcd(m_val)); end
    end
  endtask

  task automatic test_random();
    logic [7:0] lv;
    for (int i = 0; i < 400; i++) begin
      lv = 8'($urandom_range(0, 255));
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 6) == 0), lv,
            ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1);
      n_cmp++; if (if2.tc !== exp_tc()) begin n_err++; $display("FAIL rnd_tc step %0d got %b want %b", i, if2.tc, exp_tc()); end
      tick();
      n_cmp++; if (if2.q !== to_bcd(m_val)) begin n_err++; $display("FAIL rnd_q step %0d got %h want %h", i, if2.q, to_bcd(m_val)); end
      n_cmp++; if (if2.wrap !== m_wrap) begin n_err++; $display("FAIL rnd_wrap step %0d got %b want %b", i, if2.wrap, m_wrap); end
      n_cmp++; if (if2.load_err !== m_lerr) begin n_err++; $display("FAIL rnd_lerr step %0d got %b want %b", i, if2.load_err, m_lerr); end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_priority();
    test_async_reset();
    test_cascade();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
